// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
// Included by ahb_error_slave and ahb_err_log.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } errslv_state_t;

endpackage

// File: rtl/ahb_err_log.sv
// Error log for the default slave: captures the last faulting address phase,
// keeps a saturating error count and produces a one-cycle interrupt pulse.
module ahb_err_log
    import ahb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int COUNT_W = 8
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               capture_i,
    input  logic               clear_i,
    input  logic               irqSet_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic               write_i,
    input  logic [2:0]         size_i,
    output logic [ADDR_W-1:0]  errAddr_o,
    output logic               errWrite_o,
    output logic [2:0]         errSize_o,
    output logic [COUNT_W-1:0] errCount_o,
    output logic               errIrq_o
);

    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic               write_q, write_d;
    logic [2:0]         size_q,  size_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               irq_q;

    // A capture wins over a clear so the new fault is never lost; the clear
    // then only restarts the count from this transfer.
    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        count_d = count_q;
        if (capture_i) begin
            addr_d  = addr_i;
            write_d = write_i;
            size_d  = size_i;
            if (clear_i) begin
                count_d = COUNT_W'(1);
            end else if (count_q != '1) begin
                count_d = count_q + COUNT_W'(1);
            end
        end else if (clear_i) begin
            addr_d  = '0;
            write_d = 1'b0;
            size_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            count_q <= count_d;
            irq_q   <= irqSet_i;
        end
    end

    assign errAddr_o  = addr_q;
    assign errWrite_o = write_q;
    assign errSize_o  = size_q;
    assign errCount_o = count_q;
    assign errIrq_o   = irq_q;

endmodule

// File: rtl/ahb_error_slave.sv
// AHB-Lite default slave: zero-wait OKAY for IDLE/BUSY, two-cycle ERROR after
// WAIT_STATES wait cycles for NONSEQ/SEQ. Error log built only with ERROR_SLAVE_LOG_EN.
module ahb_error_slave
    import ahb_pkg::*;
#(
    parameter int                DATA_W        = 64,
    parameter int                ADDR_W        = 32,
    parameter int                WAIT_STATES   = 0,
    parameter logic [63:0]       RDATA_PATTERN = 64'hABCDEF1234567890,
    parameter int                COUNT_W       = 8
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic               HREADY,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [ADDR_W-1:0]  HADDR,
    input  logic [DATA_W-1:0]  HWDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [DATA_W-1:0]  HRDATA,
    input  logic               log_clr,
    output logic [ADDR_W-1:0]  err_addr,
    output logic               err_write,
    output logic [2:0]         err_size,
    output logic [COUNT_W-1:0] err_count,
    output logic               err_irq
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    errslv_state_t state_q, state_d;
    logic [3:0]    waitCnt_q, waitCnt_d;
    logic          accept;

    // Only the HTRANS MSB matters: NONSEQ and SEQ are both faulted.
    assign accept = HSEL & HREADY & HTRANS[1];

    // IDLE and ERR2 are the only states where HREADY can be high, so they
    // are the only states that look at a new address phase.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d   = ST_WAIT;
                        waitCnt_d = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    state_d = ST_ERR1;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = RDATA_PATTERN[DATA_W-1:0];

`ifdef ERROR_SLAVE_LOG_EN
    logic logCapture;
    logic unusedInputs;

    assign logCapture   = accept & HREADYOUT;
    assign unusedInputs = ^{HWDATA, HTRANS[0]};

    ahb_err_log #(
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W)
    ) u_log (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .capture_i  (logCapture),
        .clear_i    (log_clr),
        .irqSet_i   (state_d == ST_ERR1),
        .addr_i     (HADDR),
        .write_i    (HWRITE),
        .size_i     (HSIZE),
        .errAddr_o  (err_addr),
        .errWrite_o (err_write),
        .errSize_o  (err_size),
        .errCount_o (err_count),
        .errIrq_o   (err_irq)
    );
`else
    logic unusedInputs;

    assign unusedInputs = ^{HWDATA, HTRANS[0], HADDR, HWRITE, HSIZE, log_clr};
    assign err_addr     = '0;
    assign err_write    = 1'b0;
    assign err_size     = '0;
    assign err_count    = '0;
    assign err_irq      = 1'b0;
`endif

endmodule
